// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM states and
// the multiply iteration count.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  // The shift-add multiplier runs one iteration per operand bit.
  localparam int unsigned MUL_ITER   = DATA_W_DEF;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StWb
  } state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier datapath (no control FSM).
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears all state)
//   load        - capture multiplicand a / multiplier b, clear acc and counter
//   step        - perform one iteration
//   a, b        - operands captured on load
//   prod        - accumulator value including the current iteration's add
//   last        - current iteration is the final one (counter == ITER-1)
module seq_mul #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITER   = alu_pkg::MUL_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] prod,
  output logic              last
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_step;

  // Exposed combinationally so the final iteration's add lands in the result.
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign prod     = acc_step;
  assign last     = (cnt_q == CntW'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage between the register file read ports and its write port.
// Single-cycle ADD/SUB/AND/OR/XOR/SLL/SRL, iterative 16-step MUL, result
// written back with a one-cycle wb_wen pulse. busy covers writeback.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start, op, a, b, dest - request; sampled on an edge where busy=0
//   busy                  - operation in flight (through writeback)
//   wb_wen/wb_wadr/wb_data - register file write port (WEN/WADR/DIN)
//   zero, carry           - flags of the last written result
module alu_exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              wb_wen,
  output logic [ADDR_W-1:0] wb_wadr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero,
  output logic              carry
);

  import alu_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0] dest_q;
  logic              wen_q, zero_q, carry_q;
  logic [DATA_W-1:0] data_q;

  logic              accept, wr, mul_step, mul_last;
  logic [DATA_W-1:0] mul_prod, alu_res, res_d;
  logic              alu_carry, carry_d;
  logic [DATA_W:0]   sum, diff;

  seq_mul #(
    .DATA_W (DATA_W),
    .ITER   (DATA_W)
  ) u_seq_mul (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (mul_step),
    .a    (a),
    .b    (b),
    .prod (mul_prod),
    .last (mul_last)
  );

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, a_q} + {1'b0, b_q};
    // Bit DATA_W of the widened difference is the unsigned borrow.
    diff      = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  end
      OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = a_q << b_q[3:0];
      OP_SRL: alu_res = a_q >> b_q[3:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr       = 1'b0;
    mul_step = 1'b0;
    res_d    = alu_res;
    carry_d  = alu_carry;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (op == OP_MUL) ? StMul : StExec;
        end
      end
      StExec: begin
        wr      = 1'b1;
        state_d = StWb;
      end
      StMul: begin
        mul_step = 1'b1;
        if (mul_last) begin
          wr      = 1'b1;
          res_d   = mul_prod;
          carry_d = 1'b0;
          state_d = StWb;
        end
      end
      StWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wr;
      if (accept) begin
        op_q   <= op;
        a_q    <= a;
        b_q    <= b;
        dest_q <= dest;
      end
      if (wr) begin
        data_q  <= res_d;
        zero_q  <= (res_d == '0);
        carry_q <= carry_d;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign wb_wen  = wen_q;
  assign wb_wadr = dest_q;
  assign wb_data = data_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [3:0]  dest;
  logic        busy, wb_wen, zero, carry;
  logic [3:0]  wb_wadr;
  logic [15:0] wb_data;

  int tests = 0;
  int fails = 0;
  int wen_cnt = 0;
  logic [15:0] rf [16];

  alu_exec_unit #(
    .DATA_W (16),
    .ADDR_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .dest    (dest),
    .busy    (busy),
    .wb_wen  (wb_wen),
    .wb_wadr (wb_wadr),
    .wb_data (wb_data),
    .zero    (zero),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  // Register file model: counts write strobes and captures written data.
  always @(negedge clk) begin
    if (wb_wen === 1'b1) begin
      wen_cnt++;
      rf[wb_wadr] = wb_data;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check latency, result, flags and busy release.
  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    int exp_lat;
    start = 1'b1; op = v.op; a = v.a; b = v.b; dest = v.dest;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d busy_after_accept", idx), {31'd0, busy}, 32'd1);
    cyc = 1;
    tick();
    while (wb_wen !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    exp_lat = (v.op == 3'd7) ? 16 : 1;
    chk($sformatf("v%0d wen_latency", idx), cyc, exp_lat);
    chk($sformatf("v%0d data", idx), {16'd0, wb_data}, {16'd0, v.res});
    chk($sformatf("v%0d wadr", idx), {28'd0, wb_wadr}, {28'd0, v.dest});
    chk($sformatf("v%0d zero", idx), {31'd0, zero}, {31'd0, v.z});
    chk($sformatf("v%0d carry", idx), {31'd0, carry}, {31'd0, v.c});
    chk($sformatf("v%0d busy_in_wb", idx), {31'd0, busy}, 32'd1);
    tick();
    chk($sformatf("v%0d wen_one_cycle", idx), {31'd0, wb_wen}, 32'd0);
    chk($sformatf("v%0d busy_released", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vec_t v;

    //           op    a         b         dest  res       z     c
    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{3'd1, 16'h0005, 16'h0007, 4'd1, 16'hFFFE, 1'b0, 1'b1};
    vecs[2]  = '{3'd5, 16'h0001, 16'h000F, 4'd2, 16'h8000, 1'b0, 1'b0};
    vecs[3]  = '{3'd6, 16'h8000, 16'h0004, 4'd4, 16'h0800, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 16'hF0F0, 16'h3CFF, 4'd5, 16'h30F0, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 16'hF000, 16'h000F, 4'd6, 16'hF00F, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 4'd7, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{3'd5, 16'h1234, 16'h0010, 4'd8, 16'h1234, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 16'h1234, 16'h1111, 4'd9, 16'h2345, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 16'h0007, 16'h0005, 4'hA, 16'h0002, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 16'h0123, 16'h0010, 4'hB, 16'h1230, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 16'h8000, 16'h0002, 4'hC, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 16'h0000, 16'hFFFF, 4'hD, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{3'd7, 16'h00FF, 16'h0101, 4'hE, 16'hFFFF, 1'b0, 1'b0};
    vecs[14] = '{3'd1, 16'h0005, 16'h0005, 4'hF, 16'h0000, 1'b1, 1'b0};

    // Reset with start held: request must be dropped, everything zero.
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001; dest = 4'd3;
    tick();
    tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst wen", {31'd0, wb_wen}, 32'd0);
    chk("rst data", {16'd0, wb_data}, 32'd0);
    chk("rst zero", {31'd0, zero}, 32'd0);
    chk("rst carry", {31'd0, carry}, 32'd0);
    chk("rst wadr", {28'd0, wb_wadr}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst no_write", wen_cnt, 0);
    chk("rst idle_after", {31'd0, busy}, 32'd0);

    for (int i = 0; i < NV; i++) run_op(vecs[i], i);

    // Hold start with a different op through busy: only one write, and the
    // following op reading r5 sees the freshly written value.
    base = wen_cnt;
    start = 1'b1; op = 3'd0; a = 16'h0100; b = 16'h0023; dest = 4'd5;
    tick();
    op = 3'd4; a = 16'hFFFF; b = 16'h0F0F; dest = 4'd6;
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick();
    start = 1'b0;
    chk("hold one_write", wen_cnt - base, 1);
    chk("hold r5", {16'd0, rf[5]}, 32'h0000_0123);
    v = '{3'd0, rf[5], 16'h0001, 4'd7, 16'h0124, 1'b0, 1'b0};
    run_op(v, 100);
    chk("hold r7", {16'd0, rf[7]}, 32'h0000_0124);

    // Reset at MUL iteration 8 (also with start asserted): no write ever.
    base = wen_cnt;
    start = 1'b1; op = 3'd7; a = 16'h0003; b = 16'h0005; dest = 4'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mulrst busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1; start = 1'b1; op = 3'd0;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("mulrst busy", {31'd0, busy}, 32'd0);
    chk("mulrst data", {16'd0, wb_data}, 32'd0);
    chk("mulrst zero", {31'd0, zero}, 32'd0);
    v = '{3'd0, 16'h0002, 16'h0003, 4'd4, 16'h0005, 1'b0, 1'b0};
    run_op(v, 200);
    for (int i = 0; i < 20; i++) tick();
    chk("mulrst single_write", wen_cnt - base, 1);
    chk("mulrst r4", {16'd0, rf[4]}, 32'h0000_0005);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute stage directly downstream of the 16x16 register file; upstream of its write port.
- Takes operands from the file's two read ports (`OUT1`/`OUT2`) and runs one of eight operations: single-cycle ADD/SUB/logic/shift, or a 16-iteration shift-add MUL.
- Writes the result back through a one-cycle `WEN`/`WADR`/`DIN` pulse.
- Holds `busy` through writeback, so a following operation never reads a stale register.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width (must match register file width)
- `ADDR_W`, 4, destination register address width

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  request; accepted only on an edge where `busy`=0
- `op`  in  3  operation code, sampled at accept
- `a`  in  DATA_W  operand A (from register file `OUT1`), sampled at accept
- `b`  in  DATA_W  operand B (from register file `OUT2`), sampled at accept
- `dest`  in  ADDR_W  destination register, sampled at accept
- `busy`  out  1  high from the edge after accept until writeback completes
- `wb_wen`  out  1  one-cycle write strobe; connects to register file `WEN`
- `wb_wadr`  out  ADDR_W  write address; connects to `WADR`
- `wb_data`  out  DATA_W  write data; connects to `DIN`
- `zero`  out  1  result == 0; updated with each `wb_wen`
- `carry`  out  1  ADD carry-out / SUB borrow; 0 for all other ops

## Operation
Op encoding:
- 0 ADD: a+b
- 1 SUB: a−b
- 2 AND
- 3 OR
- 4 XOR
- 5 SLL: a << b[3:0]
- 6 SRL: a >> b[3:0], logical
- 7 MUL: low DATA_W bits of a*b

Arithmetic rules:
- All results wrap modulo 2^DATA_W.
- ADD: `carry` = bit DATA_W of the (DATA_W+1)-bit sum.
- SUB: `carry` = 1 iff a < b (unsigned borrow).

States:
- IDLE: `busy`=0. `start`=1 latches op/a/b/dest and goes to MUL if op=7, otherwise EXEC.
- EXEC: computes the result and registers it into `wb_data`/`zero`/`carry`; sets `wb_wen`=1; goes to WB.
- MUL: one iteration per edge, counter 0..DATA_W−1. Each iteration: if multiplier bit 0 is 1, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. After the iteration where the counter equals DATA_W−1, registers acc into `wb_data`, sets `wb_wen`=1, goes to WB.
- WB: `wb_wen` is high during this state; next edge clears `wb_wen` and goes to IDLE.

Boundary conditions:
- `start` while `busy`=1: ignored entirely, no queuing; latched operands remain unchanged.
- `rst`=1 on any edge, including mid-MUL or in WB: state→IDLE, all outputs→0, counter/acc cleared, no write issued.
- `rst` and `start` on the same edge: reset wins; the request is dropped.
- Shift amount 0: result = a. MUL with either operand 0: result 0, still takes the full DATA_W iterations (fixed latency).
- `wb_wadr` holds the latched `dest` from accept through WB.

## Timing
- Reset value of every output: 0.
- Accept at edge k.
- Non-MUL ops:
  - EXEC during k..k+1; `wb_wen`=1 during k+1..k+2.
  - Register file writes at edge k+2.
  - `busy`=0 after k+2; earliest next accept is edge k+3.
- MUL:
  - `wb_wen`=1 during k+16..k+17; `busy`=0 after k+17.
  - Earliest next accept is edge k+18.
- `busy` rises on edge k.
- Because `busy` covers writeback, operands read after `busy` falls already reflect the previous result.
- `zero`/`carry` hold their values until the next `wb_wen` or reset.

## Structure
- Package `alu_pkg` holds:
  - op code constants: `OP_ADD`..`OP_MUL`
  - state enum: IDLE/EXEC/MUL/WB
  - `MUL_ITER` = DATA_W
- One sub-module, `seq_mul`: the iterative shift-add datapath (acc, multiplicand, multiplier, counter, `load`/`step` inputs, `last` output). The FSM stays in `alu_exec_unit`.

## Test plan
- Reset: assert `rst` for 2 edges with `start`=1 → `busy`, `wb_wen`, `wb_data`, `zero`, `carry` all 0; no write.
- ADD a=0xFFFF b=0x0001 dest=3 → `wb_wen` exactly one cycle at k+1, `wb_wadr`=3, `wb_data`=0x0000, `zero`=1, `carry`=1; `busy` falls after k+2.
- SUB a=0x0005 b=0x0007 → 0xFFFE, `carry`=1, `zero`=0; SLL a=0x0001 b=0x000F → 0x8000; SRL a=0x8000 b=0x0004 → 0x0800.
- MUL a=0x0123 b=0x0010 → `wb_data`=0x1230 with `wb_wen` at k+16; MUL 0x8000×0x0002 → 0x0000, `zero`=1.
- Wire to the register file: ADD into r5, hold `start` with a new op throughout `busy` → exactly one `wb_wen`; the next op, reading r5, sees the new value.
- Assert `rst` at MUL iteration 8 → no `wb_wen` ever pulses for that op; `busy`=0 after the reset edge; a fresh ADD is accepted on the next edge and completes normally.
